// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands in a small FIFO, drives them one at a
// time to an external combinational ALU, and returns each captured result
// with its tag over a valid/ready response port.
// The optional accumulator is enabled by defining ALU_SEQ_ACC_EN: it adds the
// cmd_acc input and lets a command take operand A from the last result.
module alu_op_sequencer #(
  parameter int DEPTH = 4  // command FIFO entries; power of two, at least 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_sel,
  input  logic [3:0]  cmd_tag,
`ifdef ALU_SEQ_ACC_EN
  input  logic        cmd_acc,
`endif
  // ALU side
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic [3:0]  rsp_tag,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // One queued command. The acc flag only exists when the accumulator does.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [3:0]  tag;
`ifdef ALU_SEQ_ACC_EN
    logic        acc;
`endif
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t        state;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    tag_reg;
  entry_t        wr_entry;
  entry_t        head;
  logic [31:0]   issue_a;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Pack the incoming command into a FIFO entry.
  always_comb begin
    wr_entry     = '0;
    wr_entry.a   = cmd_a;
    wr_entry.b   = cmd_b;
    wr_entry.sel = cmd_sel;
    wr_entry.tag = cmd_tag;
`ifdef ALU_SEQ_ACC_EN
    wr_entry.acc = cmd_acc;
`endif
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  // A new entry is taken either from IDLE or straight out of RESP on a
  // handshake, so a busy queue never pays an IDLE bubble between results.
  assign pop = !empty &&
               ((state == S_IDLE) || ((state == S_RESP) && rsp_valid && rsp_ready));

  assign busy = (state != S_IDLE) || !empty;

`ifdef ALU_SEQ_ACC_EN
  logic [31:0] acc_reg;

  // Accumulator follows every captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (state == S_ISSUE) begin
      acc_reg <= alu_out;
    end
  end

  // An acc-flagged entry chains on the previous result instead of its own A.
  assign issue_a = head.acc ? acc_reg : head.a;
`else
  assign issue_a = head.a;
`endif

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two; the extra
  // count bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      tag_reg   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_tag   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            alu_a   <= issue_a;
            alu_b   <= head.b;
            alu_sel <= head.sel;
            tag_reg <= head.tag;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ALU operands have been stable for a full cycle; sample the result.
          rsp_data  <= alu_out;
          rsp_carry <= alu_carry;
          rsp_tag   <= tag_reg;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          // Everything on the response port holds until the consumer takes it.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_a   <= issue_a;
              alu_b   <= head.b;
              alu_sel <= head.sel;
              tag_reg <= head.tag;
              state   <= S_ISSUE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: models the external ALU, keeps a scoreboard
// of expected {carry, data, tag} per accepted command and compares each
// response handshake in order. Define ALU_SEQ_ACC_EN to cover the accumulator.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [3:0]  cmd_sel = '0;
  logic [3:0]  cmd_tag = '0;
`ifdef ALU_SEQ_ACC_EN
  logic        cmd_acc = 1'b0;
`endif
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_carry;
  logic [3:0]  rsp_tag;
  logic        busy;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .cmd_tag   (cmd_tag),
`ifdef ALU_SEQ_ACC_EN
    .cmd_acc   (cmd_acc),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  // External ALU reference: returns {carry, result}. Undefined opcodes give a
  // distinctive value with carry set so pass-through is observable.
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
    logic [32:0] r;
    r = '0;
    case (s)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, ~a};
      4'd6:    r = {1'b0, a << b[4:0]};
      4'd7:    r = {1'b0, a >> b[4:0]};
      4'd8:    r = {32'd0, (a < b)};
      4'd9:    r = {32'd0, (a == b)};
      default: r = {1'b1, a + b + 32'h0000_1000};
    endcase
    return r;
  endfunction

  // Combinational ALU attached to the sequencer.
  always_comb begin
    {alu_carry, alu_out} = ref_alu(alu_a, alu_b, alu_sel);
  end

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          rsp_count = 0;
  int          last_rsp_cyc = -1;
  int          base;
  bit          check_gap = 1'b0;
  bit          rand_bp = 1'b0;
  bit          stalled = 1'b0;
  bit          acc_fire;
  bit          rsp_fire;
  logic [36:0] held;
  logic [36:0] next_exp;
  logic [36:0] exp_q[$];
  logic [36:0] e;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock: scoreboard work at the falling edge, then advance past the
  // rising edge so the caller can drive the next inputs.
  task automatic cycle();
    @(negedge clk);
    acc_fire = cmd_valid && cmd_ready;
    rsp_fire = rsp_valid && rsp_ready;
    if (stalled) begin
      check("rsp_hold", {27'd0, rsp_valid, rsp_carry, rsp_data, rsp_tag}, {27'd0, 1'b1, held});
    end
    if (acc_fire) begin
      exp_q.push_back(next_exp);
    end
    if (rsp_fire) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", {63'd0, rsp_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp", {27'd0, rsp_carry, rsp_data, rsp_tag}, {27'd0, e});
        $display("rsp #%0d tag=%0d data=%h carry=%0d", rsp_count, rsp_tag, rsp_data, rsp_carry);
      end
      if (check_gap && last_rsp_cyc >= 0) begin
        check("rsp_gap", 64'(cyc - last_rsp_cyc), 64'd2);
      end
      last_rsp_cyc = cyc;
      rsp_count++;
    end
    stalled = rsp_valid && !rsp_ready;
    held    = {rsp_carry, rsp_data, rsp_tag};
    @(posedge clk);
    #1;
    cyc++;
    if (rand_bp) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one command until accepted (bounded), recording its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                      input logic [3:0] tag, input logic [32:0] exp_cd);
    int n;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    cmd_tag   = tag;
    next_exp  = {exp_cd, tag};
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc_fire && n < 200);
    if (!acc_fire) check("accept_timeout", {63'd0, acc_fire}, 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    cmd_valid = 1'b0;
    for (int i = 0; i < budget && (exp_q.size() != 0 || rsp_valid); i++) cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- reset values
    #2 rst_n = 1'b0;
    #1;
    check("reset_ctrl", {61'd0, cmd_ready, rsp_valid, busy}, {61'd0, 3'b100});
    check("reset_alu", {alu_sel, alu_b, alu_a[27:0]}, 64'd0);
    check("reset_rsp", {27'd0, rsp_carry, rsp_data, rsp_tag}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- single add with latency: accepted at edge N, valid after N+2
    rsp_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'd1, 4'd0, 4'd3, {1'b1, 32'h0000_0000});
    check("lat_n0_valid", {63'd0, rsp_valid}, 64'd0);
    check("lat_n0_busy", {63'd0, busy}, 64'd1);
    cycle();
    check("lat_n1_valid", {63'd0, rsp_valid}, 64'd0);
    check("lat_n1_alu_a", {32'd0, alu_a}, {32'd0, 32'hFFFF_FFFF});
    cycle();
    check("lat_n2_rsp", {26'd0, rsp_valid, rsp_carry, rsp_data, rsp_tag},
          {26'd0, 1'b1, 1'b1, 32'h0, 4'd3});
    drain(20);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("alu_hold", {28'd0, alu_sel, alu_a}, {28'd0, 4'd0, 32'hFFFF_FFFF});

    // ---- fill with rsp_ready low: DEPTH+1 accepted, then full
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send(32'd100 + 32'(i), 32'd1, 4'd0, 4'(8 + i), {1'b0, 32'd101 + 32'(i)});
    end
    check("full_ready", {63'd0, cmd_ready}, 64'd0);
    cmd_valid = 1'b1;
    cmd_a = 32'd7; cmd_b = 32'd9; cmd_sel = 4'd3; cmd_tag = 4'd13;
    next_exp = {1'b0, 32'd15, 4'd13};
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("full_stall_ready", {63'd0, cmd_ready}, 64'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    check("slot_freed_ready", {63'd0, cmd_ready}, 64'd1);
    send(32'd7, 32'd9, 4'd3, 4'd13, {1'b0, 32'd15});
    drain(60);

    // ---- back-to-back, one result every second cycle
    base = rsp_count;
    check_gap = 1'b1;
    last_rsp_cyc = -1;
    send(32'd10,          32'd3,          4'd1, 4'd1, {1'b1, 32'd7});
    send(32'hF0,          32'h3C,         4'd2, 4'd2, {1'b0, 32'h30});
    send(32'hFF00,        32'h0FF0,       4'd4, 4'd3, {1'b0, 32'hF0F0});
    send(32'h0,           32'h0,          4'd5, 4'd4, {1'b0, 32'hFFFF_FFFF});
    send(32'h8000_0001,   32'd1,          4'd6, 4'd5, {1'b0, 32'h0000_0002});
    send(32'd5,           32'd5,          4'd9, 4'd6, {1'b0, 32'd1});
    drain(60);
    check_gap = 1'b0;
    check("b2b_count", 64'(rsp_count - base), 64'd6);

    // ---- undefined opcode passes through to the ALU
    send(32'h10, 32'h20, 4'hC, 4'd9, {1'b1, 32'h0000_1030});
    drain(20);

    // ---- random backpressure with random operations
    base = rsp_count;
    rand_bp = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rs;
      ra = $urandom();
      rb = $urandom();
      rs = 4'($urandom_range(0, 15));
      send(ra, rb, rs, 4'(i), ref_alu(ra, rb, rs));
    end
    drain(400);
    rand_bp = 1'b0;
    rsp_ready = 1'b1;
    check("bp_count", 64'(rsp_count - base), 64'd12);

    // ---- reset while in ISSUE with three entries queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'd50 + 32'(i), 32'd2, 4'd0, 4'(i), {1'b0, 32'd52 + 32'(i)});
    end
    rsp_ready = 1'b1;
    send(32'd60, 32'd2, 4'd0, 4'd4, {1'b0, 32'd62});
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_ctrl", {61'd0, cmd_ready, rsp_valid, busy}, {61'd0, 3'b100});
    check("mid_reset_data", {alu_sel, alu_a, rsp_data[27:0]}, 64'd0);
    check("mid_reset_tag", {59'd0, rsp_carry, rsp_tag}, 64'd0);
    exp_q.delete();
    stalled = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = rsp_count;
    for (int i = 0; i < 12; i++) cycle();
    check("post_reset_no_rsp", 64'(rsp_count - base), 64'd0);
    check("post_reset_ctrl", {61'd0, cmd_ready, rsp_valid, busy}, {61'd0, 3'b100});

`ifdef ALU_SEQ_ACC_EN
    // ---- accumulator chaining
    cmd_acc = 1'b0;
    send(32'd5, 32'd7, 4'd0, 4'd1, {1'b0, 32'd12});
    cmd_acc = 1'b1;
    send(32'd999, 32'd1, 4'd0, 4'd2, {1'b0, 32'd13});
    cmd_acc = 1'b0;
    drain(40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
